// File: rtl/upcounter_seq_ctrl.sv
// upcounter_seq_ctrl: sequencer that owns the count register of a WIDTH-bit
// up-counter. A start runs one count from 0 to a latched limit, with
// pause/resume, abort and a one-cycle done pulse at the terminal count.
//
// Build option: define AUTO_RELOAD_EN for periodic mode. In that mode the
// done state reloads the count to 0 and keeps running until stop is seen.
// Without it the done state always returns to idle.
//
// Handshake: none. start/stop are levels sampled on every rising clk edge.
// When both are high, stop has priority in every state.
// Outputs: out is registered; busy, paused and done decode state_q only, so
// there is no combinational path from any input to any output.
// The state register state_q is the point to watch when debugging this block.
module upcounter_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             paused,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] out_inc;

    assign out_inc = out_q + WIDTH'(1);

`ifdef AUTO_RELOAD_EN
    // rld_q marks a count that began from a reload rather than from idle.
    // Such a count dwells one extra cycle at lim_q before entering done.
    // This gives a reload period of limit+2 cycles, and it keeps limit==0
    // periodic instead of letting it run away.
    logic rld_q, rld_d;

    // Reload marker register
    always_ff @(posedge clk) begin
        if (!rst) rld_q <= 1'b0;
        else      rld_q <= rld_d;
    end
`endif

    // State, count and latched-limit registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            lim_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            lim_q   <= lim_d;
        end
    end

    // Next-state, next-count and limit-capture logic
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        lim_d   = lim_q;
`ifdef AUTO_RELOAD_EN
        rld_d   = rld_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    lim_d   = limit;
                    out_d   = '0;
                    state_d = (limit == '0) ? S_DONE : S_RUN;
`ifdef AUTO_RELOAD_EN
                    rld_d   = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_HOLD;
                end else begin
`ifdef AUTO_RELOAD_EN
                    if (rld_q && (out_q == lim_q)) begin
                        state_d = S_DONE;
                    end else begin
                        out_d = out_inc;
                        if (!rld_q && (out_inc == lim_q)) state_d = S_DONE;
                    end
`else
                    out_d = out_inc;
                    if (out_inc == lim_q) state_d = S_DONE;
`endif
                end
            end
            S_HOLD: begin
                if (stop) begin
                    out_d   = '0;
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
`ifdef AUTO_RELOAD_EN
                if (stop) begin
                    state_d = S_IDLE;
                end else begin
                    out_d   = '0;
                    rld_d   = 1'b1;
                    state_d = S_RUN;
                end
`else
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from state only
    always_comb begin
        out    = out_q;
        paused = (state_q == S_HOLD);
        done   = (state_q == S_DONE);
`ifdef AUTO_RELOAD_EN
        busy   = (state_q != S_IDLE);
`else
        busy   = (state_q == S_RUN) || (state_q == S_HOLD);
`endif
    end

endmodule
